// File: rtl/fifo_gearbox.sv
// fifo_gearbox: circular-buffer FIFO that accepts IN_W-bit words and unloads
// each word as RATIO = IN_W/OUT_W chunks of OUT_W bits, one chunk per read.
//
// Ports:
//   Clk        system clock, rising edge
//   Rst        synchronous active-high reset
//   wr, DB     write strobe and IN_W-bit write word
//   rd         read strobe, one chunk per accepted read
//   clr_err    clears the sticky overflow/underflow flags
//   out        registered read chunk
//   out_vld    out was loaded by an accepted read on the previous edge
//   full       level == DEPTH
//   empty      level == 0
//   afull      level >= AFULL_LVL
//   level      stored words, including a partially read head word
//   overflow   sticky: a write was dropped
//   underflow  sticky: a read was rejected
module fifo_gearbox #(
    parameter int unsigned IN_W      = 8,
    parameter int unsigned OUT_W     = 4,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned AFULL_LVL = 480,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              wr,
    input  logic [IN_W-1:0]   DB,
    input  logic              rd,
    input  logic              clr_err,
    output logic [OUT_W-1:0]  out,
    output logic              out_vld,
    output logic              full,
    output logic              empty,
    output logic              afull,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned RATIO  = IN_W / OUT_W;
    localparam int unsigned CIDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    localparam logic [CIDX_W-1:0] LAST_IDX  = CIDX_W'(RATIO - 1);
    localparam logic [ADDR_W:0]   DEPTH_LVL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   AFULL_THR = (ADDR_W + 1)'(AFULL_LVL);

    logic [IN_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CIDX_W-1:0] chunk_idx;

    logic              wr_acc;
    logic              rd_acc;
    logic              retire;
    logic [IN_W-1:0]   head;
    logic [IN_W-1:0]   head_sh;
    int unsigned       shamt;
    logic [OUT_W-1:0]  chunk;

    // Status is decoded from level only; pointers are never compared.
    assign full  = (level == DEPTH_LVL);
    assign empty = (level == '0);
    assign afull = (level >= AFULL_THR);

    assign wr_acc = wr & ~full;
    assign rd_acc = rd & ~empty;
    assign retire = rd_acc & (chunk_idx == LAST_IDX);

    // Chunk select: shift the head word so the wanted chunk lands in the low bits.
    always_comb begin
        head = mem[rd_ptr];
        if (MSB_FIRST) begin
            shamt = (RATIO - 1 - 32'(chunk_idx)) * OUT_W;
        end else begin
            shamt = 32'(chunk_idx) * OUT_W;
        end
        head_sh = head >> shamt;
        chunk   = head_sh[OUT_W-1:0];
    end

    // Storage has no reset; only the pointers define valid contents.
    always_ff @(posedge Clk) begin
        if (!Rst && wr_acc) begin
            mem[wr_ptr] <= DB;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            chunk_idx <= '0;
            level     <= '0;
            out       <= '0;
            out_vld   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end

            out_vld <= rd_acc;
            if (rd_acc) begin
                out <= chunk;
                if (retire) begin
                    chunk_idx <= '0;
                    rd_ptr    <= rd_ptr + ADDR_W'(1);
                end else begin
                    chunk_idx <= chunk_idx + CIDX_W'(1);
                end
            end

            // Simultaneous accept and retire leaves level unchanged.
            if (wr_acc && !retire) begin
                level <= level + (ADDR_W + 1)'(1);
            end else if (!wr_acc && retire) begin
                level <= level - (ADDR_W + 1)'(1);
            end

            // A new error event in the same cycle as clr_err wins.
            if (wr && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end

            if (rd && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_gearbox.sv
// Bench for fifo_gearbox: two instances (MSB-first and LSB-first) share one
// stimulus stream; a word-level model predicts status and pushes expected
// chunks into queues that are popped whenever the DUT flags out_vld.
module tb_fifo_gearbox;

    localparam int IN_W      = 8;
    localparam int OUT_W     = 4;
    localparam int ADDR_W    = 9;
    localparam int DEPTH     = 512;
    localparam int AFULL_LVL = 480;
    localparam int RATIO     = IN_W / OUT_W;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              wr;
    logic [IN_W-1:0]   DB;
    logic              rd;
    logic              clr_err;

    logic [OUT_W-1:0]  out_m,  out_l;
    logic              vld_m,  vld_l;
    logic              full_m, full_l;
    logic              empty_m, empty_l;
    logic              afull_m, afull_l;
    logic [ADDR_W:0]   level_m, level_l;
    logic              ovf_m,  ovf_l;
    logic              unf_m,  unf_l;

    fifo_gearbox #(
        .IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .AFULL_LVL(AFULL_LVL), .MSB_FIRST(1'b1)
    ) u_dut (
        .Clk(Clk), .Rst(Rst), .wr(wr), .DB(DB), .rd(rd), .clr_err(clr_err),
        .out(out_m), .out_vld(vld_m), .full(full_m), .empty(empty_m), .afull(afull_m),
        .level(level_m), .overflow(ovf_m), .underflow(unf_m)
    );

    fifo_gearbox #(
        .IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .AFULL_LVL(AFULL_LVL), .MSB_FIRST(1'b0)
    ) u_dut_lsb (
        .Clk(Clk), .Rst(Rst), .wr(wr), .DB(DB), .rd(rd), .clr_err(clr_err),
        .out(out_l), .out_vld(vld_l), .full(full_l), .empty(empty_l), .afull(afull_l),
        .level(level_l), .overflow(ovf_l), .underflow(unf_l)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [IN_W-1:0]  m_q [$];
    logic [OUT_W-1:0] exp_m_q [$];
    logic [OUT_W-1:0] exp_l_q [$];
    int               m_cidx;
    bit               m_ovf, m_unf, m_vld;
    logic [OUT_W-1:0] m_out_m, m_out_l;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, then sample #1 after the edge.
    task automatic cycle(input bit w, input logic [IN_W-1:0] d, input bit r, input bit c,
                         input bit rs);
        bit f_pre, e_pre;
        Rst     = rs;
        wr      = w;
        DB      = d;
        rd      = r;
        clr_err = c;
        f_pre   = (m_q.size() == DEPTH);
        e_pre   = (m_q.size() == 0);
        if (rs) begin
            m_q.delete();
            exp_m_q.delete();
            exp_l_q.delete();
            m_cidx  = 0;
            m_ovf   = 0;
            m_unf   = 0;
            m_vld   = 0;
            m_out_m = '0;
            m_out_l = '0;
        end else begin
            m_vld = r && !e_pre;
            if (m_vld) begin
                exp_m_q.push_back(OUT_W'(m_q[0] >> (OUT_W * (RATIO - 1 - m_cidx))));
                exp_l_q.push_back(OUT_W'(m_q[0] >> (OUT_W * m_cidx)));
                if (m_cidx == RATIO - 1) begin
                    void'(m_q.pop_front());
                    m_cidx = 0;
                end else begin
                    m_cidx++;
                end
            end
            if (w && !f_pre) m_q.push_back(d);
            if (w && f_pre) m_ovf = 1;
            else if (c) m_ovf = 0;
            if (r && e_pre) m_unf = 1;
            else if (c) m_unf = 0;
        end
        @(posedge Clk);
        #1;
        check("out_vld", 32'(vld_m), 32'(m_vld));
        check("out_vld_lsb", 32'(vld_l), 32'(m_vld));
        if (vld_m) begin
            if (exp_m_q.size() == 0) check("spurious_vld", 32'(vld_m), 32'd0);
            else m_out_m = exp_m_q.pop_front();
        end
        if (vld_l) begin
            if (exp_l_q.size() == 0) check("spurious_vld_lsb", 32'(vld_l), 32'd0);
            else m_out_l = exp_l_q.pop_front();
        end
        check("out", 32'(out_m), 32'(m_out_m));
        check("out_lsb", 32'(out_l), 32'(m_out_l));
        check("level", 32'(level_m), 32'(m_q.size()));
        check("empty", 32'(empty_m), 32'(m_q.size() == 0));
        check("full", 32'(full_m), 32'(m_q.size() == DEPTH));
        check("afull", 32'(afull_m), 32'(m_q.size() >= AFULL_LVL));
        check("overflow", 32'(ovf_m), 32'(m_ovf));
        check("underflow", 32'(unf_m), 32'(m_unf));
    endtask

    int written;
    bit w_s, r_s;

    initial begin
        // Reset and basic word 0xA5: MSB order 0xA,0x5; LSB order 0x5,0xA
        cycle(0, 8'h00, 0, 0, 1);
        cycle(0, 8'h00, 0, 0, 1);
        cycle(0, 8'h00, 0, 0, 0);
        cycle(1, 8'hA5, 0, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 0, 0, 0);

        // Read on empty with concurrent write of 0x11
        cycle(1, 8'h11, 1, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 0, 1, 0);

        // Fill to full, overflow on write 513, clear, drain everything
        for (int i = 0; i < DEPTH; i++) cycle(1, 8'(i), 0, 0, 0);
        cycle(1, 8'h3C, 0, 0, 0);
        cycle(0, 8'h00, 0, 1, 0);
        for (int i = 0; i < DEPTH * RATIO; i++) cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 0, 0, 0);

        // Full plus retiring read in the same cycle: write still dropped
        for (int i = 0; i < DEPTH; i++) cycle(1, 8'(i * 3 + 1), 0, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        cycle(1, 8'h77, 1, 0, 0);
        check("level_after_full_rw", 32'(level_m), 32'(DEPTH - 1));
        for (int i = 0; i < (DEPTH - 1) * RATIO; i++) cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 1, 1, 0);
        cycle(0, 8'h00, 0, 1, 0);

        // Streaming with wrap-around of both pointers
        written = 0;
        cycle(1, 8'h00, 0, 0, 0);
        written = 1;
        for (int cyc = 0; cyc < 6000 && (written < 700 || m_q.size() > 0); cyc++) begin
            w_s = (written < 700) && (m_q.size() < 100) && ($urandom_range(0, 3) != 0);
            r_s = ((m_q.size() > 1) || (written == 700 && m_q.size() > 0))
                  && ($urandom_range(0, 2) != 0);
            cycle(w_s, 8'(written * 7 + 3), r_s, 0, 0);
            if (w_s) written++;
        end
        check("stream_written", 32'(written), 32'd700);
        check("stream_drained", 32'(level_m), 32'd0);

        // Reset in the middle of a word
        for (int i = 0; i < 10; i++) cycle(1, 8'(8'h30 + i), 0, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 0, 0, 1);
        cycle(0, 8'h00, 1, 0, 0);
        cycle(1, 8'h5A, 0, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_gearbox.md
Name: fifo_gearbox

Overview:
- Parametrised successor to the byte-in, narrow-out FIFO.
- Stores IN_W-bit words written on DB/wr in a DEPTH-entry circular buffer.
- Unloads each word as RATIO = IN_W/OUT_W chunks of OUT_W bits on explicit rd requests.
- Adds empty/full/almost-full status, an occupancy count, sticky overflow/underflow flags with clear, and selectable chunk order.

Parameters:
- IN_W, 8, write word width; must be an integer multiple of OUT_W.
- OUT_W, 4, read chunk width; RATIO = IN_W/OUT_W, with RATIO >= 1.
- ADDR_W, 9, address width; DEPTH = 2**ADDR_W words.
- AFULL_LVL, 480, afull asserts when level >= AFULL_LVL.
- MSB_FIRST, 1, 1 = most significant chunk of a word read first, 0 = least significant first.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- wr  in  1  write strobe; one word per cycle while high.
- DB  in  IN_W  write data.
- rd  in  1  read strobe; one chunk per cycle while high.
- clr_err  in  1  clears the sticky overflow and underflow flags.
- out  out  OUT_W  registered read chunk.
- out_vld  out  1  out was updated by an accepted read this cycle.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- afull  out  1  level >= AFULL_LVL.
- level  out  ADDR_W+1  words stored, including a partially read head word.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (Rst=1 at a Clk edge):
  - wr_ptr, rd_ptr, chunk_idx, level, out, out_vld, overflow and underflow all go to 0.
  - Memory contents are not reset.
  - Reset overrides every other input, including mid-word reads.
- Status outputs full, empty and afull are combinational from level. After reset, empty=1 and full=afull=0.
- Write accept:
  - A write is accepted when wr=1 and full=0, where full is the value before the edge.
  - On accept: mem[wr_ptr] <= DB, wr_ptr increments modulo DEPTH.
  - wr=1 while full=1: data is dropped, nothing else changes, and overflow <= 1.
- Read accept:
  - A read is accepted when rd=1 and empty=0, where empty is the value before the edge.
  - On accept: out <= the chunk chunk_idx of mem[rd_ptr], and out_vld <= 1 on the next cycle.
  - Latency is 1 cycle from the rd edge to a valid out.
- Chunk order:
  - MSB_FIRST=1: chunk k = bits [IN_W-1-k*OUT_W -: OUT_W].
  - MSB_FIRST=0: chunk k = bits [k*OUT_W +: OUT_W].
- Chunk sequencing:
  - chunk_idx increments on each accepted read.
  - When chunk_idx == RATIO-1, chunk_idx <= 0 and rd_ptr increments modulo DEPTH; the head word is retired.
- Read rejection:
  - rd=1 while empty=1: out holds its value, out_vld <= 0, underflow <= 1.
  - With rd=0, out holds its value and out_vld <= 0.
- Level:
  - +1 on an accepted write.
  - -1 on a retiring read.
  - Unchanged when both happen in the same cycle, or when neither does.
- Simultaneous events:
  - full and a retiring read in the same cycle: the write is still rejected, overflow=1, level=DEPTH-1.
  - empty and a write in the same cycle: the read is rejected (underflow=1), the write is accepted, level=1.
  - clr_err together with a new error event in the same cycle: the flag is set (set wins).
- Wrap-around: pointers are ADDR_W bits and wrap naturally. Full and empty come from level, never from pointer compare.
- Out-of-range values are impossible: level never exceeds DEPTH and never goes below 0.

Test Plan (defaults unless stated):
- Reset, then write 0xA5, then rd on 2 consecutive cycles -> out=0xA then 0x5, out_vld=1 on the cycle after each rd; level stays 1 after the first rd, 0 and empty=1 after the second.
- Same stimulus with MSB_FIRST=0 -> out=0x5 then 0xA.
- 512 back-to-back writes of i mod 256 -> afull=1 after write 480, full=1 and level=512 after write 512. A 513th write of 0x3C is dropped and overflow=1. Draining all 1024 chunks returns 0,0,0,1,0,2,... with no 0x3C. Pulsing clr_err then clears overflow.
- rd on empty after reset -> underflow=1, out=0, out_vld=0. Concurrent wr of 0x11 -> level=1. A following rd pair yields 0x1 then 0x1.
- Fill to full, read one chunk, then assert wr and rd together (the rd retires the head word) -> write rejected, overflow=1, level=511.
- Streaming: 700 words written with interleaved reads, keeping level between 1 and 100 -> pointers wrap past 511 and all 1400 chunks emerge in order.
- 10 writes, 1 chunk read, then Rst for 1 cycle mid-word -> level=0, empty=1, out=0, out_vld=0, flags=0. The next rd gives underflow=1; a new write then reads back from chunk 0.
